// File: rtl/seq_mul_add.sv
// seq_mul_add: sequential signed multiply-add, Result = A*B + C, one multiplier bit per cycle
//
// Recomposes the dividend from restoring-divider outputs (Quotient->A, Divisor->B, Remainder->C).
// Parameter WIDTH: operand width (two's complement); Result is 2*WIDTH bits.
// Ports:
//   Clock, Reset_n      rising-edge clock, asynchronous active-low reset
//   Start               level request, sampled only in IDLE; must drop before the next operation
//   A, B, C             signed multiplicand, multiplier, addend (C sign-extended)
//   Result, Overflow    registered A*B+C and "does not fit in WIDTH signed bits"
//   Busy, Done          high in WORK / high in DONE
// Optional feature SEQ_MUL_ADD_EARLY_EXIT_EN: leave WORK as soon as the remaining multiplier is zero.
module seq_mul_add #(
  parameter int WIDTH = 16
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic               Start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [WIDTH-1:0]   C,
  output logic [2*WIDTH-1:0] Result,
  output logic               Overflow,
  output logic               Busy,
  output logic               Done
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, WORK, DONE} state_t;
  state_t               state;
  logic [2*WIDTH-1:0]   mcand, acc, c_ext, sum;
  logic [WIDTH-1:0]     mplier;
  logic [CW-1:0]        count;
  logic                 sign, finish, ovf;
`ifdef SEQ_MUL_ADD_EARLY_EXIT_EN
  assign finish = (count == CW'(WIDTH)) || (mplier == '0);
`else
  assign finish = count == CW'(WIDTH);
`endif
  // |A*B| <= 2^(2*WIDTH-2), so negating and adding C cannot wrap in 2*WIDTH bits
  assign sum = (sign ? -acc : acc) + c_ext;
  // fits in WIDTH signed bits only if the top WIDTH+1 bits are all equal
  assign ovf = !((&sum[2*WIDTH-1:WIDTH-1]) || !(|sum[2*WIDTH-1:WIDTH-1]));
  assign Busy = state == WORK;
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      mcand    <= '0;
      acc      <= '0;
      c_ext    <= '0;
      mplier   <= '0;
      count    <= '0;
      sign     <= 1'b0;
      Result   <= '0;
      Overflow <= 1'b0;
      Done     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (Start) begin
          // magnitudes as unsigned WIDTH-bit values: the most negative input maps to 2^(WIDTH-1)
          mcand  <= {{WIDTH{1'b0}}, (A[WIDTH-1] ? -A : A)};
          mplier <= B[WIDTH-1] ? -B : B;
          sign   <= A[WIDTH-1] ^ B[WIDTH-1];
          c_ext  <= {{WIDTH{C[WIDTH-1]}}, C};
          acc    <= '0;
          count  <= '0;
          state  <= WORK;
        end
        WORK: if (finish) begin
          Result   <= sum;
          Overflow <= ovf;
          Done     <= 1'b1;
          state    <= DONE;
        end else begin
          acc    <= mplier[0] ? acc + mcand : acc;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
        end
        DONE: if (!Start) begin
          Done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
